// File: rtl/mod12_load_sched.sv
// Round-robin arbiter granting exclusive sessions on a shared MOD-12 loadable counter.
// The owner's start value is loaded, the counter runs to terminal count, and a done/err pulse closes the session.
`timescale 1ns/1ps
module mod12_load_sched #(
   parameter int N   = 4,
   parameter int MOD = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [4*N-1:0]   req_data,
   output logic [N-1:0]     gnt,
   output logic [N-1:0]     done,
   output logic [N-1:0]     err,
   output logic             busy,
   output logic             cnt_rst,
   output logic             cnt_load,
   output logic [3:0]       cnt_data,
   input  logic [3:0]       cnt_count
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int WW = $clog2(MOD + 1);
   localparam logic [4:0]    MOD5  = 5'(MOD);
   localparam logic [3:0]    TERM4 = 4'(MOD - 1);
   localparam logic [WW-1:0] WMOD  = WW'(MOD);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   ptr, ptr_nxt, owner, owner_nxt, win, cand;
   logic            found;
   logic [3:0]      win_data, cnt_data_nxt;
   logic [N-1:0]    gnt_nxt, err_nxt;
   logic [WW-1:0]   wdog, wdog_nxt;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
      return (x == IW'(N - 1)) ? '0 : x + 1'b1;
   endfunction

   function automatic logic [N-1:0] onehot(input logic [IW-1:0] x);
      return {{(N-1){1'b0}}, 1'b1} << x;
   endfunction

   // First pending requester at or after ptr, wrapping around
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = IW'((int'(ptr) + i) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < N; i++) begin
         if (win == IW'(i)) win_data = req_data[4*i +: 4];
      end
   end

   // Terminal count beats abort, abort beats watchdog
   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      owner_nxt    = owner;
      gnt_nxt      = gnt;
      cnt_data_nxt = cnt_data;
      err_nxt      = '0;
      wdog_nxt     = '0;
      case (state)
         IDLE: begin
            if (found) begin
               if ({1'b0, win_data} >= MOD5) begin
                  err_nxt = onehot(win);
                  ptr_nxt = wrap_inc(win);
               end else begin
                  gnt_nxt      = onehot(win);
                  owner_nxt    = win;
                  cnt_data_nxt = win_data;
                  state_nxt    = LOAD;
               end
            end
         end
         LOAD: state_nxt = RUN;
         RUN: begin
            wdog_nxt = wdog + 1'b1;
            if (cnt_count == TERM4) begin
               state_nxt = DONE;
            end else if (!req[owner]) begin
               gnt_nxt   = '0;
               ptr_nxt   = wrap_inc(owner);
               state_nxt = IDLE;
            end else if (wdog == WMOD) begin
               err_nxt   = onehot(owner);
               gnt_nxt   = '0;
               ptr_nxt   = wrap_inc(owner);
               state_nxt = IDLE;
            end
         end
         DONE: begin
            gnt_nxt   = '0;
            ptr_nxt   = wrap_inc(owner);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         owner    <= '0;
         gnt      <= '0;
         err      <= '0;
         cnt_data <= '0;
         wdog     <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         owner    <= owner_nxt;
         gnt      <= gnt_nxt;
         err      <= err_nxt;
         cnt_data <= cnt_data_nxt;
         wdog     <= wdog_nxt;
      end
   end

   assign done     = (state == DONE) ? gnt : '0;
   assign busy     = (state != IDLE);
   assign cnt_rst  = (state == IDLE) || (state == DONE);
   assign cnt_load = (state == LOAD);

endmodule

// File: tb/tb_mod12_load_sched.sv
// Self-checking bench for mod12_load_sched with a behavioural counter and a session-timing reference model.
`timescale 1ns/1ps
module tb_mod12_load_sched;

   localparam int N   = 4;
   localparam int MOD = 12;
   localparam int HMAX = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic [3:0]  gnt, done, err;
   logic        busy, cnt_rst, cnt_load;
   logic [3:0]  cnt_data, cnt_count;
   bit          stuck;

   int total = 0;
   int bad   = 0;
   int model_ptr;

   logic [3:0] e_gnt  [0:HMAX];
   logic [3:0] e_done [0:HMAX];
   logic [3:0] e_err  [0:HMAX];
   logic [3:0] e_cdat [0:HMAX];
   bit         e_busy [0:HMAX];
   bit         e_load [0:HMAX];

   always #5 clk = ~clk;

   mod12_load_sched #(.N(N), .MOD(MOD)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .gnt(gnt), .done(done), .err(err), .busy(busy),
      .cnt_rst(cnt_rst), .cnt_load(cnt_load), .cnt_data(cnt_data),
      .cnt_count(cnt_count)
   );

   // Behavioural MOD-12 counter; 'stuck' freezes it after a load
   always @(posedge clk) begin
      if (cnt_rst)       cnt_count <= 4'd0;
      else if (cnt_load) cnt_count <= cnt_data;
      else if (stuck)    cnt_count <= cnt_count;
      else               cnt_count <= (cnt_count == 4'd11) ? 4'd0 : cnt_count + 4'd1;
   end

   task automatic do_reset();
      rst = 1'b1; req = '0; req_data = '0; stuck = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_ptr = 0;
   endtask

   task automatic check_idle_outputs(input string name);
      total++;
      if (gnt !== 4'b0 || done !== 4'b0 || err !== 4'b0 || busy !== 1'b0 ||
          cnt_rst !== 1'b1 || cnt_load !== 1'b0 || cnt_data !== 4'd0) begin
         bad++;
         $display("[TB] FAIL %s got gnt=%b done=%b err=%b busy=%b rst=%b load=%b data=%0d exp 0000/0000/0000/0/1/0/0",
                  name, gnt, done, err, busy, cnt_rst, cnt_load, cnt_data);
      end
   endtask

   // Predict per-cycle outputs from session rules, then drive and compare
   task automatic run_sched(input string name, input logic [3:0] mask, input logic [15:0] data,
                            input bit keep, input int h);
      logic [3:0]  pend, oh;
      logic [15:0] tmp;
      int t, w, v, p;
      for (int n = 0; n <= HMAX; n++) begin
         e_gnt[n] = '0; e_done[n] = '0; e_err[n] = '0; e_cdat[n] = '0;
         e_busy[n] = 1'b0; e_load[n] = 1'b0;
      end
      pend = mask; p = model_ptr; t = 0;
      while (pend != 4'b0 && t < h) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && pend[2'((p + k) % N)]) w = (p + k) % N;
         tmp = data >> (4 * w);
         v   = int'(tmp[3:0]);
         oh  = 4'b0001 << w;
         p   = (w + 1) % N;
         if (!keep) pend = pend & ~oh;
         if (v >= MOD) begin
            if (t + 1 <= h) e_err[t + 1] = oh;
            t = t + 1;
         end else begin
            for (int n = t + 1; n <= t + 14 - v; n++)
               if (n <= h) begin e_gnt[n] = oh; e_busy[n] = 1'b1; end
            if (t + 1 <= h) begin e_load[t + 1] = 1'b1; e_cdat[t + 1] = 4'(v); end
            if (t + 14 - v <= h) e_done[t + 14 - v] = oh;
            t = t + 15 - v;
         end
      end
      model_ptr = p;
      req_data = data;
      req = mask;
      for (int n = 1; n <= h; n++) begin
         @(negedge clk);
         total += 6;
         if (gnt !== e_gnt[n]) begin
            bad++; $display("[TB] FAIL %s c%0d gnt got=%b exp=%b", name, n, gnt, e_gnt[n]);
         end
         if (done !== e_done[n]) begin
            bad++; $display("[TB] FAIL %s c%0d done got=%b exp=%b", name, n, done, e_done[n]);
         end
         if (err !== e_err[n]) begin
            bad++; $display("[TB] FAIL %s c%0d err got=%b exp=%b", name, n, err, e_err[n]);
         end
         if (busy !== e_busy[n]) begin
            bad++; $display("[TB] FAIL %s c%0d busy got=%b exp=%b", name, n, busy, e_busy[n]);
         end
         if (cnt_load !== e_load[n]) begin
            bad++; $display("[TB] FAIL %s c%0d cnt_load got=%b exp=%b", name, n, cnt_load, e_load[n]);
         end
         if (cnt_rst !== (!e_busy[n] || e_done[n] != 4'b0)) begin
            bad++; $display("[TB] FAIL %s c%0d cnt_rst got=%b", name, n, cnt_rst);
         end
         if (e_load[n]) begin
            total++;
            if (cnt_data !== e_cdat[n]) begin
               bad++; $display("[TB] FAIL %s c%0d cnt_data got=%0d exp=%0d", name, n, cnt_data, e_cdat[n]);
            end
         end
         if (!keep) req = req & ~(done | err);
      end
      req = '0;
   endtask

   task automatic test_reset();
      do_reset();
      check_idle_outputs("reset");
   endtask

   task automatic test_single();
      run_sched("single_v8", 4'b0001, 16'h0008, 1'b0, 10);
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_sched("rr_all10", 4'b1111, 16'hAAAA, 1'b1, 27);
      do_reset();
   endtask

   task automatic test_illegal();
      run_sched("illegal13", 4'b0100, 16'h0D00, 1'b0, 6);
      run_sched("after_illegal", 4'b1111, 16'h5B3A, 1'b0, 70);
   endtask

   task automatic test_abort();
      req_data = 16'h0020; req = 4'b0010;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         total++;
         if (gnt !== 4'b0010) begin
            bad++; $display("[TB] FAIL abort_gnt c%0d got=%b exp=0010", n, gnt);
         end
      end
      req = 4'b0000;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0 || done !== 4'b0 || err !== 4'b0 || cnt_rst !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL abort_end got gnt=%b done=%b err=%b rst=%b busy=%b exp 0000/0000/0000/1/0",
                         gnt, done, err, cnt_rst, busy);
      end
      model_ptr = 2;
      run_sched("after_abort", 4'b1111, 16'h9B47, 1'b0, 70);
   endtask

   task automatic test_watchdog();
      stuck = 1'b1;
      req_data = 16'h5000; req = 4'b1000;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         total++;
         if (gnt !== 4'b1000 || err !== 4'b0 || done !== 4'b0) begin
            bad++; $display("[TB] FAIL wdog_run c%0d got gnt=%b err=%b done=%b exp 1000/0000/0000", n, gnt, err, done);
         end
      end
      @(negedge clk);
      total++;
      if (err !== 4'b1000 || gnt !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin
         bad++; $display("[TB] FAIL wdog_err got err=%b gnt=%b busy=%b done=%b exp 1000/0000/0/0000", err, gnt, busy, done);
      end
      req = '0; stuck = 1'b0;
      @(negedge clk);
      total++;
      if (err !== 4'b0) begin
         bad++; $display("[TB] FAIL wdog_pulse got err=%b exp=0000", err);
      end
      model_ptr = 0;
   endtask

   task automatic test_reset_mid_run();
      req_data = 16'h0000; req = 4'b0010;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         if (n == 1) begin
            total++;
            if (gnt !== 4'b0010) begin
               bad++; $display("[TB] FAIL rst_run_gnt got=%b exp=0010", gnt);
            end
         end
      end
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset_mid_run");
      rst = 1'b0; req = '0;
      model_ptr = 0;
      run_sched("post_reset", 4'b0010, 16'h0000, 1'b0, 20);
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         run_sched("random", 4'($urandom_range(1, 15)), 16'($urandom), 1'b0, 70);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_illegal();
      test_abort();
      test_watchdog();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
